// File: rtl/fmul_norm_round.sv
// binary64 multiplier back end: normalizes the 116-bit significand product,
// rounds per rm, resolves specials and packs the result in a 2-stage pipe.
module fmul_norm_round (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [115:0] prod,
    input  logic         sign,
    input  logic [12:0]  exp_in,
    input  logic [1:0]   rm,
    input  logic         in_zero,
    input  logic         in_inf,
    input  logic         in_nan,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  result,
    output logic [2:0]   flags
);

    localparam logic [1:0] RNE = 2'd0;
    localparam logic [1:0] RUP = 2'd2;
    localparam logic [1:0] RDN = 2'd3;

    logic               s1_valid;
    logic               s2_valid;
    logic               s1_adv;
    logic [51:0]        s1_mant;
    logic               s1_g;
    logic               s1_r;
    logic               s1_s;
    logic signed [12:0] s1_e;
    logic               s1_sign;
    logic [1:0]         s1_rm;
    logic               s1_zero;
    logic               s1_inf;
    logic               s1_nan;

    logic               hi;
    logic [51:0]        n_mant;
    logic               n_g;
    logic               n_r;
    logic               n_s;
    logic signed [12:0] n_e;

    logic               inc;
    logic               inexact;
    logic               carry;
    logic [51:0]        mant_r;
    logic signed [12:0] e_f;
    logic [63:0]        res_c;
    logic [2:0]         flg_c;

    assign s1_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s1_adv;
    assign out_valid = s2_valid;

    // Product of two [1,2) significands lies in [1,4); bit 115 picks the shift.
    always_comb begin
        hi     = prod[115];
        n_mant = hi ? prod[114:63] : prod[113:62];
        n_g    = hi ? prod[62] : prod[61];
        n_r    = hi ? prod[61] : prod[60];
        n_s    = hi ? |prod[60:0] : |prod[59:0];
        n_e    = exp_in + {12'b0, hi};
    end

    always_comb begin
        inexact = s1_g || s1_r || s1_s;
        inc     = 1'b0;
        unique case (s1_rm)
            RNE:     inc = s1_g && (s1_r || s1_s || s1_mant[0]);
            RUP:     inc = !s1_sign && inexact;
            RDN:     inc = s1_sign && inexact;
            default: inc = 1'b0;
        endcase
        // Carry out of the fraction means the significand rounded up to 2.0.
        {carry, mant_r} = {1'b0, s1_mant} + {52'b0, inc};
        e_f = s1_e + {12'b0, carry};
        res_c = {s1_sign, e_f[10:0], mant_r};
        flg_c = {2'b00, inexact};
        if (s1_nan) begin
            res_c = 64'h7FF8000000000000;
            flg_c = 3'b000;
        end else if (s1_inf) begin
            res_c = {s1_sign, 11'h7FF, 52'h0};
            flg_c = 3'b000;
        end else if (s1_zero) begin
            res_c = {s1_sign, 63'h0};
            flg_c = 3'b000;
        end else if (e_f >= 13'sd2047) begin
            flg_c = 3'b101;
            if (s1_rm == RNE || (s1_rm == RUP && !s1_sign) ||
                (s1_rm == RDN && s1_sign))
                res_c = {s1_sign, 11'h7FF, 52'h0};
            else
                res_c = {s1_sign, 11'h7FE, {52{1'b1}}};
        end else if (e_f <= 13'sd0) begin
            res_c = {s1_sign, 63'h0};
            flg_c = 3'b011;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            result   <= 64'h0;
            flags    <= 3'b000;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_mant <= n_mant;
                    s1_g    <= n_g;
                    s1_r    <= n_r;
                    s1_s    <= n_s;
                    s1_e    <= n_e;
                    s1_sign <= sign;
                    s1_rm   <= rm;
                    s1_zero <= in_zero;
                    s1_inf  <= in_inf;
                    s1_nan  <= in_nan;
                end
            end
            if (s1_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    result <= res_c;
                    flags  <= flg_c;
                end
            end
        end
    end

endmodule
